// File: rtl/switch_pkg.sv
// rtl/switch_pkg.sv - shared packet format constants, FSM state enums and length helper for the switch egress path
package switch_pkg;

    localparam int BLOCK_WORDS = 8;
    localparam int LEN_LSB     = 21;
    localparam int LEN_MSB     = 26;
    localparam int LEN_W       = 9;

    localparam int WORD_HDR    = 0;
    localparam int WORD_DMAC   = 1;
    localparam int WORD_TSTAMP = 2;

    typedef enum logic [1:0] {
        RX_IDLE,
        RX_STORE,
        RX_DROP
    } rx_state_t;

    typedef enum logic [1:0] {
        TX_IDLE,
        TX_FETCH,
        TX_SEND
    } tx_state_t;

    // Packet size in words from the header length field; a zero length means one block.
    function automatic logic [LEN_W-1:0] pkt_words(input logic [LEN_MSB-LEN_LSB:0] blocks);
        logic [LEN_MSB-LEN_LSB:0] b;
        b = blocks;
        if (b == '0) begin
            b = 6'd1;
        end
        return LEN_W'(b) * LEN_W'(BLOCK_WORDS);
    endfunction

endpackage

// File: rtl/simple_dual_port_mem.sv
// rtl/simple_dual_port_mem.sv - one write port, one registered read port; read data holds while rd_en is low
module simple_dual_port_mem #(
    parameter int MEM_SIZE   = 1024,
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = $clog2(MEM_SIZE)
) (
    input  logic                  clk,
    input  logic                  wr_en,
    input  logic [ADDR_WIDTH-1:0] wr_addr,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic                  rd_en,
    input  logic [ADDR_WIDTH-1:0] rd_addr,
    output logic [DATA_WIDTH-1:0] rd_data
);

    logic [DATA_WIDTH-1:0] mem [MEM_SIZE];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
        if (rd_en) begin
            rd_data <= mem[rd_addr];
        end
    end

endmodule

// File: rtl/egress.sv
// rtl/egress.sv - egress packet buffer: store-or-drop receive, committed-packet transmit; EGRESS_LATENCY_EN adds latency measurement
module egress
    import switch_pkg::*;
#(
    parameter int FIFO_DEPTH = 1024,
    parameter int TIME_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [31:0]           packet_in,
    input  logic                  packet_in_en,
    output logic [31:0]           packet_out,
    output logic                  packet_out_valid,
    input  logic                  packet_out_ready,
    output logic                  packet_out_last,
    output logic [TIME_WIDTH-1:0] latency,
    output logic                  latency_valid,
    output logic [31:0]           pkt_cnt,
    output logic [15:0]           drop_cnt,
    output logic                  is_empty,
    output logic                  is_full
);

    localparam int AW = $clog2(FIFO_DEPTH);
    typedef logic [AW:0] ptr_t;

    ptr_t wr_ptr;
    ptr_t wr_tmp;
    ptr_t rd_ptr;
    ptr_t tx_addr;
    ptr_t occupancy;
    ptr_t free_words;

    assign occupancy  = wr_ptr - rd_ptr;
    assign free_words = ptr_t'(FIFO_DEPTH) - occupancy;
    assign is_empty   = (occupancy == '0);
    assign is_full    = (occupancy == ptr_t'(FIFO_DEPTH));

    rx_state_t        rx_state, rx_next;
    logic [LEN_W-1:0] rx_len;
    logic [LEN_W-1:0] rx_idx;
    logic [LEN_W-1:0] in_len;
    logic             in_fits;
    logic             rx_last;
    logic             mem_wr_en;

    assign in_len  = pkt_words(packet_in[LEN_MSB:LEN_LSB]);
    assign in_fits = 32'(free_words) >= 32'(in_len);
    assign rx_last = (rx_idx == rx_len - LEN_W'(1));

    always_comb begin
        rx_next   = rx_state;
        mem_wr_en = 1'b0;
        case (rx_state)
            RX_IDLE: begin
                if (packet_in_en) begin
                    if (in_fits) begin
                        rx_next   = RX_STORE;
                        mem_wr_en = 1'b1;
                    end else begin
                        rx_next = RX_DROP;
                    end
                end
            end
            RX_STORE: begin
                if (packet_in_en) begin
                    mem_wr_en = 1'b1;
                    if (rx_last) begin
                        rx_next = RX_IDLE;
                    end
                end
            end
            RX_DROP: begin
                if (packet_in_en && rx_last) begin
                    rx_next = RX_IDLE;
                end
            end
            default: rx_next = RX_IDLE;
        endcase
    end

    // Words land at wr_tmp; the packet only becomes visible to TX when wr_ptr jumps on its last word.
    always_ff @(posedge clk) begin
        if (!reset) begin
            rx_state <= RX_IDLE;
            wr_ptr   <= '0;
            wr_tmp   <= '0;
            rx_len   <= '0;
            rx_idx   <= '0;
            pkt_cnt  <= '0;
            drop_cnt <= '0;
        end else begin
            rx_state <= rx_next;
            if (packet_in_en) begin
                case (rx_state)
                    RX_IDLE: begin
                        rx_len <= in_len;
                        rx_idx <= LEN_W'(1);
                        if (in_fits) begin
                            wr_tmp <= wr_tmp + ptr_t'(1);
                        end
                    end
                    RX_STORE: begin
                        rx_idx <= rx_idx + LEN_W'(1);
                        wr_tmp <= wr_tmp + ptr_t'(1);
                        if (rx_last) begin
                            wr_ptr  <= wr_tmp + ptr_t'(1);
                            pkt_cnt <= pkt_cnt + 32'd1;
                        end
                    end
                    RX_DROP: begin
                        rx_idx <= rx_idx + LEN_W'(1);
                        if (rx_last && drop_cnt != 16'hFFFF) begin
                            drop_cnt <= drop_cnt + 16'd1;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

`ifdef EGRESS_LATENCY_EN
    logic [TIME_WIDTH-1:0] curr_time;

    always_ff @(posedge clk) begin
        if (!reset) begin
            curr_time     <= '0;
            latency       <= '0;
            latency_valid <= 1'b0;
        end else begin
            curr_time     <= curr_time + TIME_WIDTH'(1);
            latency_valid <= 1'b0;
            if (packet_in_en && rx_state == RX_STORE && rx_idx == LEN_W'(WORD_TSTAMP)) begin
                latency       <= curr_time - TIME_WIDTH'(packet_in);
                latency_valid <= 1'b1;
            end
        end
    end
`else
    assign latency       = '0;
    assign latency_valid = 1'b0;
`endif

    tx_state_t        tx_state, tx_next;
    logic [LEN_W-1:0] tx_len;
    logic [LEN_W-1:0] tx_idx;
    logic [LEN_W-1:0] head_len;
    logic [31:0]      rd_data;
    logic             rd_en;
    logic             tx_fire;
    logic             tx_last;
    logic             more;

    assign head_len         = pkt_words(rd_data[LEN_MSB:LEN_LSB]);
    assign packet_out       = rd_data;
    assign packet_out_valid = (tx_state == TX_SEND);
    assign tx_fire          = packet_out_valid && packet_out_ready;
    assign tx_last          = (tx_state == TX_SEND) && (tx_idx == tx_len - LEN_W'(1));
    assign packet_out_last  = tx_last;
    // At the last word tx_addr already points at the next packet's header.
    assign more             = (wr_ptr != tx_addr);

    always_comb begin
        tx_next = tx_state;
        rd_en   = 1'b0;
        case (tx_state)
            TX_IDLE: begin
                if (!is_empty) begin
                    rd_en   = 1'b1;
                    tx_next = TX_FETCH;
                end
            end
            TX_FETCH: tx_next = TX_SEND;
            TX_SEND: begin
                if (tx_fire) begin
                    if (!tx_last || more) begin
                        rd_en = 1'b1;
                    end else begin
                        tx_next = TX_IDLE;
                    end
                end
            end
            default: tx_next = TX_IDLE;
        endcase
    end

    // Back-to-back packets stay in TX_SEND; the length is relatched from each header as it is accepted.
    always_ff @(posedge clk) begin
        if (!reset) begin
            tx_state <= TX_IDLE;
            rd_ptr   <= '0;
            tx_addr  <= '0;
            tx_len   <= '0;
            tx_idx   <= '0;
        end else begin
            tx_state <= tx_next;
            if (rd_en) begin
                tx_addr <= tx_addr + ptr_t'(1);
            end
            case (tx_state)
                TX_FETCH: begin
                    tx_len <= head_len;
                    tx_idx <= '0;
                end
                TX_SEND: begin
                    if (tx_fire) begin
                        if (tx_idx == LEN_W'(WORD_HDR)) begin
                            tx_len <= head_len;
                        end
                        if (tx_last) begin
                            rd_ptr <= rd_ptr + ptr_t'(tx_len);
                            tx_idx <= '0;
                        end else begin
                            tx_idx <= tx_idx + LEN_W'(1);
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    simple_dual_port_mem #(
        .MEM_SIZE  (FIFO_DEPTH),
        .DATA_WIDTH(32)
    ) u_mem (
        .clk    (clk),
        .wr_en  (mem_wr_en),
        .wr_addr(wr_tmp[AW-1:0]),
        .wr_data(packet_in),
        .rd_en  (rd_en),
        .rd_addr(tx_addr[AW-1:0]),
        .rd_data(rd_data)
    );

endmodule

// File: tb/tb_egress.sv
// tb/tb_egress.sv - self-checking bench for egress: scoreboard on the output stream plus table-driven packet vectors
module tb_egress;

    logic        clk;
    logic        reset;
    logic [31:0] packet_in;
    logic        packet_in_en;
    logic [31:0] packet_out;
    logic        packet_out_valid;
    logic        packet_out_ready;
    logic        packet_out_last;
    logic [31:0] latency;
    logic        latency_valid;
    logic [31:0] pkt_cnt;
    logic [15:0] drop_cnt;
    logic        is_empty;
    logic        is_full;

    egress #(
        .FIFO_DEPTH(64),
        .TIME_WIDTH(32)
    ) dut (
        .clk             (clk),
        .reset           (reset),
        .packet_in       (packet_in),
        .packet_in_en    (packet_in_en),
        .packet_out      (packet_out),
        .packet_out_valid(packet_out_valid),
        .packet_out_ready(packet_out_ready),
        .packet_out_last (packet_out_last),
        .latency         (latency),
        .latency_valid   (latency_valid),
        .pkt_cnt         (pkt_cnt),
        .drop_cnt        (drop_cnt),
        .is_empty        (is_empty),
        .is_full         (is_full)
    );

`ifdef EGRESS_LATENCY_EN
    localparam logic [31:0] LAT_037   = 32'd30;
    localparam int          PULSE_037 = 1;
`else
    localparam logic [31:0] LAT_037   = 32'd0;
    localparam int          PULSE_037 = 0;
`endif

    typedef struct {
        logic [31:0] data;
        logic        last;
    } exp_t;

    typedef struct {
        logic [5:0] lf;
        bit         store;
        bit         full;
    } vec_t;

    exp_t        exp_q[$];
    exp_t        e_mon;
    vec_t        vec[8];
    int          checks = 0;
    int          failures = 0;
    int          ready_mode = 0;
    int          lat_pulses = 0;
    int          exp_pulses = 0;
    int          exp_pkts;
    int          exp_drops;
    int          burst_words = 0;
    int          burst_target = 0;
    int          bubbles = 0;
    bit          bubble_watch = 0;
    bit          prev_stall = 0;
    logic [31:0] prev_data = '0;
    logic        prev_last = 1'b0;
    logic [31:0] exp_lat = '0;
    logic [31:0] tb_time;
    logic [15:0] seq = 16'h0100;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (!reset) tb_time <= '0;
        else        tb_time <= tb_time + 32'd1;
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=0x%0h required=0x%0h", name, act, req);
        end
    endtask

    always @(negedge clk) begin
        if (!reset) begin
            prev_stall = 1'b0;
        end else begin
            if (packet_out_valid && prev_stall) begin
                check("stall_data", 64'(packet_out), 64'(prev_data));
                check("stall_last", 64'(packet_out_last), 64'(prev_last));
            end
            if (packet_out_valid && packet_out_ready) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_word actual=0x%0h required=no_word", packet_out);
                end else begin
                    e_mon = exp_q.pop_front();
                    check("out_data", 64'(packet_out), 64'(e_mon.data));
                    check("out_last", 64'(packet_out_last), 64'(e_mon.last));
                end
                if (bubble_watch) burst_words++;
            end else if (bubble_watch && burst_words > 0 && burst_words < burst_target && !packet_out_valid) begin
                bubbles++;
            end
            prev_stall = packet_out_valid && !packet_out_ready;
            prev_data  = packet_out;
            prev_last  = packet_out_last;
            if (latency_valid) begin
                lat_pulses++;
                check("latency_value", 64'(latency), 64'(exp_lat));
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
        case (ready_mode)
            0:       packet_out_ready = 1'b0;
            1:       packet_out_ready = 1'b1;
            default: packet_out_ready = 1'($urandom_range(0, 1));
        endcase
    endtask

    task automatic do_reset();
        reset = 1'b0;
        packet_in_en = 1'b0;
        tick();
        tick();
        exp_q.delete();
        exp_lat = '0;
        reset = 1'b1;
    endtask

    // Drives up to max_words of an L-block packet; expected words are queued only if the whole packet is sent and should be stored.
    task automatic send_pkt(input logic [5:0] lf, input logic [31:0] ts, input bit store, input int max_words);
        int n;
        logic [31:0] w;
        exp_t e;
        n = ((lf == 6'd0) ? 1 : int'(lf)) * 8;
        for (int i = 0; i < n && i < max_words; i++) begin
            if (i == 0) begin
                w = {5'd0, lf, 5'd0, seq};
                seq = seq + 16'd1;
            end else if (i == 2) begin
                w = ts;
            end else begin
                w = $urandom;
            end
            if (i == 2 && store) begin
`ifdef EGRESS_LATENCY_EN
                exp_lat = tb_time - ts;
                exp_pulses++;
`endif
            end
            if (store && max_words >= n) begin
                e.data = w;
                e.last = (i == n - 1);
                exp_q.push_back(e);
            end
            packet_in = w;
            packet_in_en = 1'b1;
            tick();
        end
        packet_in_en = 1'b0;
    endtask

    task automatic drain(input int budget, input int mode);
        int k;
        k = 0;
        ready_mode = mode;
        while (!(exp_q.size() == 0 && is_empty && !packet_out_valid) && k < budget) begin
            tick();
            k++;
        end
        checks++;
        if (k >= budget) begin
            failures++;
            $display("FAIL drain_timeout actual=%0d_words_left required=0", exp_q.size());
        end
    endtask

    initial begin
        vec[0] = '{6'd1,  1'b1, 1'b0};
        vec[1] = '{6'd2,  1'b1, 1'b0};
        vec[2] = '{6'd0,  1'b1, 1'b0};
        vec[3] = '{6'd3,  1'b1, 1'b0};
        vec[4] = '{6'd8,  1'b1, 1'b1};
        vec[5] = '{6'd9,  1'b0, 1'b0};
        vec[6] = '{6'd63, 1'b0, 1'b0};
        vec[7] = '{6'd7,  1'b1, 1'b0};

        reset = 1'b0;
        packet_in = '0;
        packet_in_en = 1'b0;
        packet_out_ready = 1'b0;

        do_reset();
        check("rst_valid", 64'(packet_out_valid), 64'd0);
        check("rst_last", 64'(packet_out_last), 64'd0);
        check("rst_lat_valid", 64'(latency_valid), 64'd0);
        check("rst_latency", 64'(latency), 64'd0);
        check("rst_pkt_cnt", 64'(pkt_cnt), 64'd0);
        check("rst_drop_cnt", 64'(drop_cnt), 64'd0);
        check("rst_empty", 64'(is_empty), 64'd1);
        check("rst_full", 64'(is_full), 64'd0);

        // L=1 packet: word2=100 sampled when the time counter reads 130
        ready_mode = 1;
        for (int g = 0; g < 400 && tb_time != 32'd128; g++) tick();
        send_pkt(6'd1, 32'd100, 1'b1, 8);
        drain(200, 1);
        check("req037_latency", 64'(latency), 64'(LAT_037));
        check("req037_pulses", 64'(lat_pulses), 64'(PULSE_037));
        check("req037_pkt_cnt", 64'(pkt_cnt), 64'd1);

        do_reset();
        ready_mode = 1;
        exp_pkts = 0;
        exp_drops = 0;
        for (int i = 0; i < 8; i++) begin
            send_pkt(vec[i].lf, $urandom, vec[i].store, 512);
            check($sformatf("vec%0d_full", i), 64'(is_full), 64'(vec[i].full));
            drain(600, 1);
            if (vec[i].store) exp_pkts++;
            else              exp_drops++;
            check($sformatf("vec%0d_pkt_cnt", i), 64'(pkt_cnt), 64'(exp_pkts));
            check($sformatf("vec%0d_drop_cnt", i), 64'(drop_cnt), 64'(exp_drops));
            check($sformatf("vec%0d_empty", i), 64'(is_empty), 64'd1);
        end

        // Fill the 64-word buffer with ready low: two L=4 packets fit, the L=1 is dropped
        do_reset();
        ready_mode = 0;
        packet_out_ready = 1'b0;
        send_pkt(6'd4, $urandom, 1'b1, 32);
        send_pkt(6'd4, $urandom, 1'b1, 32);
        send_pkt(6'd1, $urandom, 1'b0, 8);
        tick();
        tick();
        check("req038_pkt_cnt", 64'(pkt_cnt), 64'd2);
        check("req038_drop_cnt", 64'(drop_cnt), 64'd1);
        check("req038_full", 64'(is_full), 64'd1);
        check("req038_valid", 64'(packet_out_valid), 64'd1);
        drain(300, 1);
        check("req038_empty", 64'(is_empty), 64'd1);

        ready_mode = 2;
        send_pkt(6'd3, $urandom, 1'b1, 24);
        drain(600, 2);
        check("req039_pkt_cnt", 64'(pkt_cnt), 64'd3);
        check("req039_drop_cnt", 64'(drop_cnt), 64'd1);

        // Reset in the middle of an L=2 packet, then one fresh L=1 packet
        do_reset();
        ready_mode = 1;
        send_pkt(6'd2, $urandom, 1'b1, 5);
        do_reset();
        check("req041_pkt_cnt_rst", 64'(pkt_cnt), 64'd0);
        check("req041_empty_rst", 64'(is_empty), 64'd1);
        send_pkt(6'd1, $urandom, 1'b1, 8);
        drain(200, 1);
        check("req041_pkt_cnt", 64'(pkt_cnt), 64'd1);

        do_reset();
        ready_mode = 1;
        burst_words = 0;
        burst_target = 1200;
        bubbles = 0;
        bubble_watch = 1'b1;
        for (int p = 0; p < 150; p++) send_pkt(6'd1, $urandom, 1'b1, 8);
        drain(400, 1);
        bubble_watch = 1'b0;
        check("req042_pkt_cnt", 64'(pkt_cnt), 64'd150);
        check("req042_drop_cnt", 64'(drop_cnt), 64'd0);
        check("req042_words", 64'(burst_words), 64'd1200);
        check("req042_bubbles", 64'(bubbles), 64'd0);

        check("latency_pulse_count", 64'(lat_pulses), 64'(exp_pulses));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout actual=running required=finished");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/egress.md
EGRESS -- requirements
Module: egress

Interface
REQ-001 Parameter FIFO_DEPTH, default 1024, SHALL set the packet buffer depth in 32-bit words (power of two, at least 64).
REQ-002 Parameter TIME_WIDTH, default 32, SHALL set the width of the free-running time counter and the latency output.
REQ-003 clk  in  1  SHALL be the single clock; all state updates on its rising edge.
REQ-004 reset  in  1  SHALL be a synchronous, active-low reset (asserted when 0).
REQ-005 packet_in  in  32  SHALL carry the crossbar word.
REQ-006 packet_in_en  in  1  SHALL qualify packet_in; one word per cycle while high.
REQ-007 packet_out  out  32  SHALL carry the egress port word.
REQ-008 packet_out_valid  out  1  SHALL indicate that packet_out is valid.
REQ-009 packet_out_ready  in  1  SHALL be the downstream accept signal.
REQ-010 packet_out_last  out  1  SHALL mark the final word of a packet.
REQ-011 latency  out  TIME_WIDTH  SHALL carry the last measured packet latency in cycles.
REQ-012 latency_valid  out  1  SHALL be a one-cycle strobe marking an update of latency.
REQ-013 pkt_cnt  out  32  SHALL count packets accepted into the buffer.
REQ-014 drop_cnt  out  16  SHALL count dropped packets; it saturates at 0xFFFF.
REQ-015 is_empty, is_full  out  1 each  SHALL report committed buffer occupancy of 0 and FIFO_DEPTH respectively.

Function
REQ-016 Packet format SHALL be L blocks of 8 words, with L taken from word0[26:21] and L=0 treated as 1.
REQ-017 Header layout SHALL be: word0 holds length and dmac[47:32]; word1 holds dmac[31:0]; word2 holds the ingress timestamp; words 3-7 hold payload; later blocks hold payload only.
REQ-018 The receive FSM SHALL have states RX_IDLE, RX_STORE and RX_DROP, and SHALL hold state when packet_in_en=0.
REQ-019 In RX_IDLE, a word with packet_in_en=1 SHALL be treated as word0, and the FSM SHALL go to RX_STORE if free words >= 8*L, otherwise to RX_DROP.
REQ-020 RX_STORE SHALL write each word at a tentative write pointer and SHALL leave the committed write pointer unchanged until the last word (index 8*L-1) is written.
REQ-021 On that last word, the committed write pointer SHALL advance by 8*L, pkt_cnt SHALL increment, and the FSM SHALL return to RX_IDLE.
REQ-022 RX_DROP SHALL consume 8*L words without writing, SHALL increment drop_cnt once, and SHALL then return to RX_IDLE.
REQ-023 Pointers SHALL wrap modulo FIFO_DEPTH, with occupancy = committed write pointer minus read pointer, carrying an extra wrap bit.
REQ-024 On word2 in RX_STORE, latency SHALL equal curr_time minus word2 (mod 2^TIME_WIDTH), with latency_valid high for exactly the next cycle.
REQ-025 The transmit FSM SHALL have states TX_IDLE, TX_FETCH and TX_SEND; it SHALL leave TX_IDLE only when a complete committed packet exists.
REQ-026 Buffer reads SHALL have one cycle of latency; TX_FETCH SHALL read word0 and latch L from it.
REQ-027 In TX_SEND, the word SHALL advance only on packet_out_valid && packet_out_ready, and packet_out and packet_out_last SHALL be held stable while valid && !ready.
REQ-028 Once the first word is presented, throughput SHALL be one word per cycle with ready held high, with no bubble between back-to-back packets.
REQ-029 After the final word is accepted, the read pointer SHALL free 8*L words and TX SHALL fetch the next packet or go to TX_IDLE.
REQ-030 Simultaneous write and read in the same cycle SHALL both take effect; free space SHALL use the committed read pointer.

Reset
REQ-031 When reset=0 at a clock edge, all pointers, counters, curr_time and latency SHALL clear to 0, both FSMs SHALL go to IDLE, packet_out_valid, packet_out_last and latency_valid SHALL go to 0, and is_empty SHALL go to 1.
REQ-032 A packet in flight at reset SHALL be discarded, and the first packet_in_en word after reset release SHALL be treated as word0.

Configuration
REQ-033 With EGRESS_LATENCY_EN defined, the curr_time counter and the latency logic SHALL be present.
REQ-034 Without EGRESS_LATENCY_EN, latency SHALL be tied to 0, latency_valid SHALL be tied to 0, and no time counter SHALL exist; all ports SHALL remain.

Structure
REQ-035 Shared package switch_pkg SHALL hold BLOCK_WORDS=8, the length field position [26:21], the header word indices, and the RX and TX state enums.
REQ-036 Storage SHALL instantiate the existing sub-module simple_dual_port_mem (MEM_SIZE=FIFO_DEPTH, DATA_WIDTH=32).

Verification
REQ-037 An L=1 packet with word2=100 arriving at curr_time=130 SHALL give latency=30 with one latency_valid pulse, 8 words out with last on word 8, and pkt_cnt=1.
REQ-038 With FIFO_DEPTH=64 and ready held low, L=4 (32 words) then L=4 then L=1 SHALL leave pkt_cnt=2, drop_cnt=1 and is_full=1.
REQ-039 Random ready toggling on an L=3 packet SHALL produce output equal to the input sequence, with no stalled word changing.
REQ-040 An L=0 header SHALL be handled as 8 words.
REQ-041 Reset pulsed at word 5 of an L=2 packet, followed by a new L=1 packet, SHALL produce only the new packet.
REQ-042 150 back-to-back L=1 packets with FIFO_DEPTH=64 and ready held high SHALL wrap the pointers, drop nothing, and keep output in order.
